// File: rtl/arith_pkg.sv
// Types and constants shared by the arithmetic unit (parallel adder, serial subtractor).
package arith_pkg;

  localparam int ARITH_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A - B - Bin over WIDTH clocks with a start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter  int WIDTH = ARITH_W,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               cell_d;
  logic               cell_bo;
  logic               load;
  logic [WIDTH-1:0]   res_next;

  sub_bit_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // A new operation may be accepted from IDLE or, back-to-back, from DONE.
  assign load     = start && (state_q == IDLE || state_q == DONE);
  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        borrow_d = cell_bo;
        res_d    = res_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = res_next;
          bout_d  = cell_bo;
          // The last bit produced is the result MSB.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = RUN;
      sa_d     = a;
      sb_d     = b;
      borrow_d = bin;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
      cnt_d    = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed results and an exhaustive sweep.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait for done; lat counts cycles after the accepting edge.
  task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                       output int lat, output int busy_cnt);
    start = 1'b1; a = a_i; b = b_i; bin = bin_i;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc, k;
    logic [W:0] exp5;
    logic       exp_ovf;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    tick();

    // 5 - 3
    do_op(4'd5, 4'd3, 1'b0, lat, bc);
    check("5m3_latency", 32'(lat), 32'd4);
    check("5m3_busy_cycles", 32'(bc), 32'd4);
    check("5m3_diff", 32'(diff), 32'h2);
    check("5m3_bout", 32'(bout), 32'd0);
    check("5m3_ovf",  32'(ovf),  32'd0);
    tick();
    check("5m3_done_one_cycle", 32'(done), 32'd0);

    // 3 - 5
    do_op(4'd3, 4'd5, 1'b0, lat, bc);
    check("3m5_diff", 32'(diff), 32'hE);
    check("3m5_bout", 32'(bout), 32'd1);
    check("3m5_ovf",  32'(ovf),  32'd0);
    tick();

    // Signed overflow both directions
    do_op(4'h8, 4'h1, 1'b0, lat, bc);
    check("8m1_diff", 32'(diff), 32'h7);
    check("8m1_bout", 32'(bout), 32'd0);
    check("8m1_ovf",  32'(ovf),  32'd1);
    tick();
    do_op(4'h7, 4'hF, 1'b0, lat, bc);
    check("7mF_diff", 32'(diff), 32'h8);
    check("7mF_bout", 32'(bout), 32'd1);
    check("7mF_ovf",  32'(ovf),  32'd1);
    tick();

    // 0 - 0 - 1, start held through DONE for a back-to-back 9 - 2
    start = 1'b1; a = 4'd0; b = 4'd0; bin = 1'b1;
    tick();
    a = 4'd9; b = 4'd2; bin = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    check("b2b_first_latency", 32'(lat), 32'd4);
    check("b2b_first_diff", 32'(diff), 32'hF);
    check("b2b_first_bout", 32'(bout), 32'd1);
    check("b2b_first_ovf",  32'(ovf),  32'd0);
    tick();
    start = 1'b0;
    k = 1;
    check("b2b_busy_after_accept", 32'(busy), 32'd1);
    while (!done && k < 40) begin tick(); k++; end
    check("b2b_spacing", 32'(k), 32'd5);
    check("b2b_second_diff", 32'(diff), 32'h7);
    check("b2b_second_bout", 32'(bout), 32'd0);
    tick();

    // start during RUN is ignored
    start = 1'b1; a = 4'd5; b = 4'd3; bin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'hF; b = 4'h0;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin tick(); lat++; end
    check("ignore_latency", 32'(lat), 32'd4);
    check("ignore_diff", 32'(diff), 32'h2);
    check("ignore_bout", 32'(bout), 32'd0);
    tick();

    // Reset at bit 2 discards the operation
    start = 1'b1; a = 4'd5; b = 4'd3; bin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    tick();
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) k++;
    end
    check("midrst_no_done", 32'(k), 32'd0);

    // Exhaustive sweep of all (a, b, bin)
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] av, bv;
      logic         cv;
      av = W'(i >> 5);
      bv = W'(i >> 1);
      cv = i[0];
      exp5 = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      exp_ovf = (av[W-1] != bv[W-1]) && (exp5[W-1] != av[W-1]);
      do_op(av, bv, cv, lat, bc);
      check($sformatf("sweep_%0h_%0h_%0h_result", av, bv, cv), 32'({bout, diff}), 32'(exp5));
      check($sformatf("sweep_%0h_%0h_%0h_ovf", av, bv, cv), 32'(ovf), 32'(exp_ovf));
      if (lat != 4) check("sweep_latency", 32'(lat), 32'd4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
